// File: rtl/coprosit_pkg.sv
// Shared types for the coprosit writeback path: report records, source ids, ECS encodings.
package coprosit_pkg;

  localparam int REPORT_ID_MAX = 16;
  localparam logic [2:0] ECSWE_POSR = 3'b010;

  typedef enum logic {
    WB_SRC_EX  = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

  // id is stored at its widest; users slice down to their ID_WIDTH
  typedef struct packed {
    logic [REPORT_ID_MAX-1:0] id;
    logic [4:0]               rd;
    logic                     err;
  } mem_report_t;

  function automatic wb_src_e wb_other(input wb_src_e s);
    return (s == WB_SRC_EX) ? WB_SRC_MEM : WB_SRC_EX;
  endfunction

endpackage

// File: rtl/coprosit_report_fifo.sv
// Circular buffer of memory result reports with occupancy count and sticky overflow flag.
module coprosit_report_fifo
  import coprosit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enq,
  input  mem_report_t enq_data,
  input  logic        deq,
  output mem_report_t head,
  output logic [AW:0] count,
  output logic        empty,
  output logic        overflow
);

  mem_report_t      mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             full, do_enq, do_deq;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign do_deq = deq & ~empty;
  // a full buffer still accepts when the head leaves in the same cycle
  assign do_enq = enq & (~full | do_deq);
  assign head   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_enq) mem[wptr] <= enq_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_enq) wptr <= wptr + 1'b1;
      if (do_deq) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_enq) - (AW+1)'(do_deq);
      if (enq & ~do_enq) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/coprosit_wb_arbiter.sv
// Writeback arbiter: shares regfile write port and result FIFO between LSU results and EX stage.
// Optional stall counter enabled with `define COPROSIT_WB_PERF_EN.
module coprosit_wb_arbiter
  import coprosit_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int POSLEN        = 32,
  parameter int ID_WIDTH      = 4,
  parameter int MEM_BUF_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mem_valid_i,
  input  logic [4:0]          mem_rd_i,
  input  logic [ID_WIDTH-1:0] mem_id_i,
  input  logic [XLEN-1:0]     mem_rdata_i,
  input  logic                mem_err_i,
  input  logic                ex_valid_i,
  output logic                ex_ready_o,
  input  logic                ex_rd_is_pos_i,
  input  logic [4:0]          ex_addr_i,
  input  logic [ID_WIDTH-1:0] ex_id_i,
  input  logic [XLEN-1:0]     ex_data_i,
  output logic                posr_we_o,
  output logic [4:0]          posr_waddr_o,
  output logic [POSLEN-1:0]   posr_wdata_o,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [ID_WIDTH-1:0] res_id_o,
  output logic [XLEN-1:0]     res_data_o,
  output logic [4:0]          res_rd_o,
  output logic                res_we_o,
  output logic [2:0]          res_ecswe_o,
  output logic                res_err_o,
  output logic                overflow_o
`ifdef COPROSIT_WB_PERF_EN
  ,
  output logic [31:0]         ex_stall_cnt_o
`endif
);

  localparam int CW = $clog2(MEM_BUF_DEPTH) + 1;

  mem_report_t   enq_rep, head;
  logic [CW-1:0] count;
  logic          empty, run, ex_hold, mem_pend, ex_pend, near_full, push;
  wb_src_e       grant, rr;
  logic          unused_id;

  assign run     = ~rst_i;
  assign enq_rep = '{id: REPORT_ID_MAX'(mem_id_i), rd: mem_rd_i, err: mem_err_i};

  coprosit_report_fifo #(.DEPTH(MEM_BUF_DEPTH)) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .enq      (mem_valid_i & run),
    .enq_data (enq_rep),
    .deq      (push & (grant == WB_SRC_MEM)),
    .head     (head),
    .count    (count),
    .empty    (empty),
    .overflow (overflow_o)
  );

  // a load owns the regfile port, so a posit-writing EX result must wait
  assign ex_hold   = mem_valid_i & ex_rd_is_pos_i;
  assign mem_pend  = ~empty;
  assign ex_pend   = ex_valid_i & ~ex_hold;
  assign near_full = (count >= CW'(MEM_BUF_DEPTH - 1));

  always_comb begin
    grant = WB_SRC_EX;
    if (mem_pend & ex_pend) grant = (near_full || rr == WB_SRC_MEM) ? WB_SRC_MEM : WB_SRC_EX;
    else if (mem_pend)      grant = WB_SRC_MEM;
  end

  assign res_valid_o = run & (mem_pend | ex_pend);
  assign push        = res_valid_o & res_ready_i;
  assign ex_ready_o  = run & (grant == WB_SRC_EX) & res_ready_i & ~ex_hold;

  always_comb begin
    res_id_o    = '0;
    res_data_o  = '0;
    res_rd_o    = '0;
    res_we_o    = 1'b0;
    res_ecswe_o = '0;
    res_err_o   = 1'b0;
    if (res_valid_o) begin
      if (grant == WB_SRC_MEM) begin
        res_id_o    = head.id[ID_WIDTH-1:0];
        res_rd_o    = head.rd;
        res_ecswe_o = ECSWE_POSR;
        res_err_o   = head.err;
      end else begin
        res_id_o    = ex_id_i;
        res_data_o  = ex_data_i;
        res_rd_o    = ex_addr_i;
        res_we_o    = ~ex_rd_is_pos_i;
        res_ecswe_o = ex_rd_is_pos_i ? ECSWE_POSR : 3'b000;
      end
    end
  end

  always_comb begin
    posr_we_o    = 1'b0;
    posr_waddr_o = '0;
    posr_wdata_o = '0;
    if (run & mem_valid_i) begin
      posr_we_o    = 1'b1;
      posr_waddr_o = mem_rd_i;
      posr_wdata_o = mem_rdata_i[POSLEN-1:0];
    end else if (ex_valid_i & ex_rd_is_pos_i & ex_ready_o) begin
      posr_we_o    = 1'b1;
      posr_waddr_o = ex_addr_i;
      posr_wdata_o = ex_data_i[POSLEN-1:0];
    end
  end

  // near-full wins against the pointer without moving it
  always_ff @(posedge clk_i) begin
    if (rst_i)                    rr <= WB_SRC_EX;
    else if (push && grant == rr) rr <= wb_other(rr);
  end

  assign unused_id = ^head.id;

`ifdef COPROSIT_WB_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                                         ex_stall_cnt_o <= '0;
    else if (ex_valid_i & ~ex_ready_o & ~&ex_stall_cnt_o) ex_stall_cnt_o <= ex_stall_cnt_o + 1'b1;
  end
`endif

endmodule

// File: tb/tb_coprosit_wb_arbiter.sv
// Scoreboard bench for coprosit_wb_arbiter: mem ids 8-15, EX ids 0-7 tell sources apart.
module tb_coprosit_wb_arbiter;

  logic        clk, rst;
  logic        mem_valid, mem_err, ex_valid, ex_ready, ex_pos, res_valid, res_ready;
  logic [4:0]  mem_rd, ex_addr, posr_waddr, res_rd;
  logic [3:0]  mem_id, ex_id, res_id;
  logic [31:0] mem_rdata, ex_data, posr_wdata, res_data;
  logic        posr_we, res_we, res_err, overflow;
  logic [2:0]  res_ecswe;
`ifdef COPROSIT_WB_PERF_EN
  logic [31:0] stall_cnt;
`endif

  coprosit_wb_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .mem_valid_i(mem_valid), .mem_rd_i(mem_rd), .mem_id_i(mem_id), .mem_rdata_i(mem_rdata),
    .mem_err_i(mem_err), .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
    .ex_rd_is_pos_i(ex_pos), .ex_addr_i(ex_addr), .ex_id_i(ex_id), .ex_data_i(ex_data),
    .posr_we_o(posr_we), .posr_waddr_o(posr_waddr), .posr_wdata_o(posr_wdata),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_id_o(res_id), .res_data_o(res_data),
    .res_rd_o(res_rd), .res_we_o(res_we), .res_ecswe_o(res_ecswe), .res_err_o(res_err),
    .overflow_o(overflow)
`ifdef COPROSIT_WB_PERF_EN
    , .ex_stall_cnt_o(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [3:0] id; logic [4:0] rd; logic err; } rep_t;
  typedef struct { logic pos; logic [4:0] addr; logic [3:0] id; logic [31:0] data; } exr_t;

  rep_t mem_q[$];
  exr_t ex_q[$];
  logic src_log[$];   // 1 = MEM push, 0 = EX push

  always @(negedge clk) begin : monitor
    rep_t r;
    exr_t e;
    if (!rst && res_valid && res_ready) begin
      if (res_id[3]) begin
        src_log.push_back(1'b1);
        if (mem_q.size() == 0) chk("mem_unexp", 1, 0);
        else begin
          r = mem_q.pop_front();
          chk("mem_id", res_id, r.id);
          chk("mem_rd", res_rd, r.rd);
          chk("mem_err", res_err, r.err);
          chk("mem_data", res_data, 0);
          chk("mem_we", res_we, 0);
          chk("mem_ecswe", res_ecswe, 3'b010);
        end
      end else begin
        src_log.push_back(1'b0);
        chk("ex_acc", ex_ready, 1);
        if (ex_q.size() == 0) chk("ex_unexp", 1, 0);
        else begin
          e = ex_q[0];
          chk("ex_id", res_id, e.id);
          chk("ex_data", res_data, e.data);
          chk("ex_rd", res_rd, e.addr);
          chk("ex_we", res_we, !e.pos);
          chk("ex_ecswe", res_ecswe, e.pos ? 3'b010 : 3'b000);
          chk("ex_err", res_err, 0);
        end
      end
    end
    if (!rst && ex_valid && ex_ready && ex_q.size() > 0) void'(ex_q.pop_front());
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic mem_put(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] d,
                         input logic err, input bit keep);
    mem_valid = 1'b1; mem_id = id; mem_rd = rd; mem_rdata = d; mem_err = err;
    if (keep) mem_q.push_back('{id: id, rd: rd, err: err});
  endtask

  task automatic ex_put(input logic pos, input logic [4:0] addr, input logic [3:0] id,
                        input logic [31:0] d);
    ex_valid = 1'b1; ex_pos = pos; ex_addr = addr; ex_id = id; ex_data = d;
    ex_q.push_back('{pos: pos, addr: addr, id: id, data: d});
  endtask

  int ex_n = 0;

  // keep EX valid for n cycles, issuing a fresh EX transaction after each accept
  task automatic ex_stream(input int n);
    logic acc;
    ex_put(1'b0, 5'(ex_n + 16), {1'b0, 3'(ex_n)}, 32'h100 + 32'(ex_n));
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      acc = ex_valid & ex_ready;
      step;
      if (acc) begin
        ex_n++;
        ex_put(1'b0, 5'(ex_n + 16), {1'b0, 3'(ex_n)}, 32'h100 + 32'(ex_n));
      end
    end
    ex_valid = 1'b0;
    ex_q.delete();
  endtask

  logic [6:0] seq;

  initial begin
    rst = 1'b1; mem_valid = 0; mem_err = 0; mem_rd = 0; mem_id = 0; mem_rdata = 0;
    ex_valid = 0; ex_pos = 0; ex_addr = 0; ex_id = 0; ex_data = 0; res_ready = 0;
    step; step;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rv", res_valid, 0);
    chk("rst_pw", posr_we, 0);
    chk("rst_rdy", ex_ready, 0);
    chk("rst_ov", overflow, 0);

    // EX result to GPR passes through in the same cycle
    step;
    res_ready = 1'b1;
    ex_put(1'b0, 5'd9, 4'd3, 32'h1234);
    @(negedge clk);
    chk("t1_rv", res_valid, 1);
    chk("t1_we", res_we, 1);
    chk("t1_data", res_data, 32'h1234);
    chk("t1_rdy", ex_ready, 1);
    chk("t1_pw", posr_we, 0);
    step;
    ex_valid = 1'b0;

    // load vs posit EX conflict: load takes the regfile, EX held
    mem_put(4'd8, 5'd5, 32'hA5A5, 1'b0, 1);
    ex_put(1'b1, 5'd7, 4'd1, 32'h77);
    @(negedge clk);
    chk("t2_pw", posr_we, 1);
    chk("t2_wa", posr_waddr, 5);
    chk("t2_wd", posr_wdata, 32'hA5A5);
    chk("t2_rdy", ex_ready, 0);
    chk("t2_rv", res_valid, 0);
    step;
    mem_valid = 1'b0;
    @(negedge clk);  // pointer sits on MEM after the first EX push
    chk("t2_gnt", res_id, 8);
    chk("t2_rdy2", ex_ready, 0);
    chk("t2_pw2", posr_we, 0);
    step;
    @(negedge clk);
    chk("t2_pw3", posr_we, 1);
    chk("t2_wa3", posr_waddr, 7);
    chk("t2_wd3", posr_wdata, 32'h77);
    chk("t2_rdy3", ex_ready, 1);
    step;
    ex_valid = 1'b0;

    // two buffered reports against a continuous EX stream: round robin
    res_ready = 1'b0;
    mem_put(4'd9, 5'd2, 32'h1, 1'b1, 1);
    step;
    mem_put(4'd10, 5'd3, 32'h2, 1'b0, 1);
    step;
    mem_valid = 1'b0;
    res_ready = 1'b1;
    src_log.delete();
    ex_n = 2;
    ex_stream(5);
    seq = '0;
    foreach (src_log[i]) if (i < 5) seq[4-i] = src_log[i];
    chk("t3_cnt", src_log.size(), 5);
    chk("t3_seq", seq[4:0], 5'b10100);

    // overflow: five enqueues into a four-entry buffer with the FIFO stalled
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_put(4'(11 + i), 5'(i), 32'(i), 1'b0, i < 4);
      step;
      if (i == 3) chk("t4_ov0", overflow, 0);
      if (i == 4) chk("t4_ov1", overflow, 1);
    end
    mem_valid = 1'b0;

    // drain from full: near-full override shows up as the second MEM grant
    res_ready = 1'b1;
    src_log.delete();
    ex_stream(7);
    seq = '0;
    foreach (src_log[i]) if (i < 7) seq[6-i] = src_log[i];
    chk("t4_cnt", src_log.size(), 7);
    chk("t4_seq", seq, 7'b1101010);
    chk("t4_ov2", overflow, 1);
    chk("t4_memq", mem_q.size(), 0);

    // reset mid-operation drops buffered reports and clears overflow
    res_ready = 1'b0;
    mem_put(4'd12, 5'd1, 32'h9, 1'b0, 0);
    step;
    rst = 1'b1;
    mem_put(4'd13, 5'd4, 32'hA, 1'b0, 0);
    @(negedge clk);
    chk("r_pw", posr_we, 0);
    chk("r_rv", res_valid, 0);
    step;
    rst = 1'b0;
    mem_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("r_rv2", res_valid, 0);
    chk("r_ov", overflow, 0);
    step;

`ifdef COPROSIT_WB_PERF_EN
    res_ready = 1'b0;
    ex_put(1'b0, 5'd1, 4'd1, 32'h55);
    repeat (6) step;
    ex_valid = 1'b0;
    ex_q.delete();
    @(negedge clk);
    chk("perf_cnt", stall_cnt, 6);
    step;
`endif

    chk("end_exq", ex_q.size(), 0);
    chk("end_memq", mem_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
